// File: rtl/bitmask_index_encoder.sv
// -----------------------------------------------------------------------------
// bitmask_index_encoder
//
// Streaming encoder: accepts an N-bit request mask over a valid/ready handshake
// and emits the binary index of every set bit, one index per output beat,
// highest bit first.
//
// Optional feature macro: BMENC_ZERO_REPORT_EN
//   defined   - an accepted all-zero mask produces one beat with out_zero=1
//   undefined - an all-zero mask is accepted and silently dropped
//
// State table:
//   IDLE | waiting for a mask, in_ready=1
//   EMIT | presenting the highest set bit of pending, one beat per handshake
//   ZREP | presenting the single empty-mask beat (zero-report build only)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   mask offered
//   in_ready   block can accept a mask
//   in_mask    request bits; bit i requests index i
//   out_valid  index beat presented
//   out_ready  consumer accepts beat
//   out_idx    index of the current set bit
//   out_last   current beat is the final beat for this mask
//   out_zero   current beat reports an empty mask
//   busy       a mask is held
// -----------------------------------------------------------------------------
module bitmask_index_encoder #(
  parameter int N    = 8,
  parameter int IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    in_mask,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic            out_zero,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_ZREP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    pending_q, pending_d;
  logic [IDXW-1:0] top_idx;
  logic            single_bit;
  logic [N-1:0]    pending_cleared;

  // Highest set bit wins: later (higher) iterations overwrite lower ones.
  always_comb begin
    top_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pending_q[i]) top_idx = IDXW'(i);
    end
  end

  // x & (x-1) removes the lowest set bit; zero result means exactly one bit.
  assign single_bit      = (pending_q != '0) &&
                           ((pending_q & (pending_q - N'(1))) == '0);
  assign pending_cleared = pending_q & ~(N'(1) << top_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          pending_d = in_mask;
          if (in_mask != '0) begin
            state_d = S_EMIT;
          end else begin
`ifdef BMENC_ZERO_REPORT_EN
            state_d = S_ZREP;
`else
            state_d = S_IDLE;
`endif
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          pending_d = pending_cleared;
          if (single_bit) state_d = S_IDLE;
        end
      end
      S_ZREP: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        pending_d = '0;
      end
    endcase
  end

  // Outputs depend only on registered state, never on in_*.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_EMIT) || (state_q == S_ZREP);
    out_idx   = (state_q == S_EMIT) ? top_idx : '0;
    out_last  = ((state_q == S_EMIT) && single_bit) || (state_q == S_ZREP);
    busy      = (state_q != S_IDLE);
`ifdef BMENC_ZERO_REPORT_EN
    out_zero  = (state_q == S_ZREP);
`else
    out_zero  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bitmask_index_encoder.sv
module tb_bitmask_index_encoder;

  localparam int N    = 8;
  localparam int IDXW = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N-1:0]    in_mask = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [IDXW-1:0] out_idx;
  logic            out_last;
  logic            out_zero;
  logic            busy;

  bitmask_index_encoder #(.N(N), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .out_zero(out_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit last;
    bit zero;
  } beat_t;

  beat_t exp_q[$];   // model: beats still owed for the current mask
  int    log_q[$];   // indices actually handed over, for literal checks
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model of an accepted mask: one beat per set bit, scanning from the top.
  function automatic void model_accept(input logic [N-1:0] m);
    int cnt = 0;
    for (int i = 0; i < N; i++) if (m[i]) cnt++;
    if (cnt == 0) begin
`ifdef BMENC_ZERO_REPORT_EN
      exp_q.push_back('{idx: 0, last: 1'b1, zero: 1'b1});
`endif
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (m[i]) begin
          cnt--;
          exp_q.push_back('{idx: i, last: (cnt == 0), zero: 1'b0});
        end
      end
    end
  endfunction

  // Single compare process: inputs change just after posedge, so at negedge
  // everything is settled for the handshake that happens at the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      check("in_ready",  int'(in_ready),  int'(exp_q.size() == 0));
      check("busy",      int'(busy),      int'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        check("out_idx",  int'(out_idx),  exp_q[0].idx);
        check("out_last", int'(out_last), int'(exp_q[0].last));
        check("out_zero", int'(out_zero), int'(exp_q[0].zero));
        if (out_ready) begin
          log_q.push_back(int'(out_idx));
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) model_accept(in_mask);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a mask until it is accepted (bounded).
  task automatic send(input logic [N-1:0] m, input bit hold_valid);
    bit rdy;
    bit done = 0;
    in_valid = 1'b1;
    in_mask  = m;
    for (int c = 0; c < 200 && !done; c++) begin
      rdy = in_ready;
      tick();
      if (rdy) done = 1;
    end
    if (!done) check("send_timeout", 0, 1);
    if (!hold_valid) in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (!out_valid && in_ready) done = 1;
      else tick();
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  task automatic check_log(input string name, input int exp[$]);
    check({name, "_count"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      check({name, "_idx"}, log_q[i], exp[i]);
  endtask

  initial begin
    int pat[4] = '{1, 0, 0, 1};
    #2;
    check("rst_in_ready",  int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_idx",   int'(out_idx), 0);
    check("rst_out_last",  int'(out_last), 0);
    check("rst_out_zero",  int'(out_zero), 0);
    check("rst_busy",      int'(busy), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // A5 at full throughput: 7,5,2,0 back to back, valid the cycle after accept
    log_q.delete();
    send(8'hA5, 0);
    check("a5_valid_next", int'(out_valid), 1);
    check("a5_first_idx", int'(out_idx), 7);
    wait_idle();
    check_log("a5", '{7, 5, 2, 0});

    // Single bit
    log_q.delete();
    send(8'h10, 0);
    check("single_last", int'(out_last), 1);
    check("single_idx", int'(out_idx), 4);
    wait_idle();
    check_log("single", '{4});

    // All ones with stalls 1,0,0,1,...
    log_q.delete();
    send(8'hFF, 0);
    for (int c = 0; c < 40 && out_valid; c++) begin
      out_ready = pat[c % 4][0];
      tick();
    end
    out_ready = 1'b1;
    wait_idle();
    check_log("ff", '{7, 6, 5, 4, 3, 2, 1, 0});

    // Empty mask
    log_q.delete();
    send(8'h00, 0);
`ifdef BMENC_ZERO_REPORT_EN
    check("zero_valid", int'(out_valid), 1);
    check("zero_flag", int'(out_zero), 1);
    wait_idle();
    check_log("zero", '{0});
`else
    for (int c = 0; c < 3; c++) begin
      check("zero_in_ready", int'(in_ready), 1);
      check("zero_no_valid", int'(out_valid), 0);
      tick();
    end
`endif

    // Reset after two beats of C3
    log_q.delete();
    send(8'hC3, 0);
    for (int c = 0; c < 50 && log_q.size() < 2; c++) tick();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_valid", int'(out_valid), 0);
    check("rst_mid_busy", int'(busy), 0);
    check_log("c3_pre", '{7, 6});
    tick();
    rst_n = 1'b1;
    tick();
    log_q.delete();
    send(8'h02, 0);
    wait_idle();
    check_log("after_rst", '{1});

    // in_mask churn during EMIT is ignored; next mask taken only when ready
    log_q.delete();
    send(8'h81, 1);
    for (int c = 0; c < 50 && !in_ready; c++) begin
      in_mask = 8'(c * 37 + 5);
      tick();
    end
    in_mask = 8'h10;
    tick();
    in_valid = 1'b0;
    in_mask  = 8'hFF;
    wait_idle();
    check_log("hold", '{7, 0, 4});

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
